// File: rtl/pipTypes.sv
// Shared pipeline types: result entries and reorder-buffer write bundles.
package pipTypes;

  localparam int ROB_IDX_W = 4;

  typedef struct packed {
    logic [31:0] result_lo;
    logic [4:0]  dest_reg;
    logic        dest_reg_valid;
  } rob_entry_t;

  typedef logic [ROB_IDX_W-1:0] rob_idx_t;

  typedef struct packed {
    logic       valid;
    rob_idx_t   idx;
    rob_entry_t data;
  } rob_wr_t;

endpackage

// File: rtl/rob_alloc_ctl.sv
// Reorder-buffer pointer control: head/tail/count, allocation grant
// and the allocated-slot range test for each result write port.
module rob_alloc_ctl
  import pipTypes::*;
#(
  parameter int DW  = ROB_IDX_W,
  parameter int NWR = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   alloc_req,
  input  logic                   retire,
  input  logic [NWR-1:0][DW-1:0] wr_idx,
  output logic                   alloc_ready,
  output logic                   accept,
  output logic [DW-1:0]          alloc_slot,
  output logic [DW-1:0]          head,
  output logic [DW:0]            count,
  output logic [NWR-1:0]         wr_alloc
);

  localparam logic [DW:0] DEPTH = {1'b1, {DW{1'b0}}};

  logic [DW-1:0] tail;

  assign alloc_ready = (count != DEPTH);
  assign accept      = alloc_req & alloc_ready;
  assign alloc_slot  = tail;

  // Slot is live when its distance from head is below the occupancy.
  for (genvar p = 0; p < NWR; p++) begin : g_alloc
    logic [DW-1:0] off;
    assign off         = wr_idx[p] - head;
    assign wr_alloc[p] = {1'b0, off} < count;
  end

  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + DW'(retire);
      tail  <= tail + DW'(accept);
      count <= count + (DW+1)'(accept) - (DW+1)'(retire);
    end
  end

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer: out-of-order result writes, in-order retire
// to the register file through registered write outputs.
module rob_commit
  import pipTypes::*;
#(
  parameter int ROB_DEPTHLOG2 = ROB_IDX_W,
  parameter int NWR           = 2
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              flush,
  input  logic                              alloc_req,
  output logic                              alloc_ready,
  output logic [ROB_DEPTHLOG2-1:0]          alloc_slot,
  input  logic [NWR-1:0]                    wr_valid,
  input  logic [NWR-1:0][ROB_DEPTHLOG2-1:0] wr_idx,
  input  rob_entry_t [NWR-1:0]              wr_data,
  output logic                              wr_err,
  output logic                              rf_wr_en,
  output logic [4:0]                        rf_wr_reg,
  output logic [31:0]                       rf_wr_data,
  output logic                              retire_valid,
  output logic [ROB_DEPTHLOG2:0]            count,
  output logic                              empty
);

  localparam int DEPTH = 1 << ROB_DEPTHLOG2;

  rob_entry_t                 entries [DEPTH];
  logic [DEPTH-1:0]           done;
  logic [ROB_DEPTHLOG2-1:0]   head;
  logic                       accept;
  logic                       retire;
  logic [NWR-1:0]             wr_alloc;
  logic [NWR-1:0]             wr_ok;
  rob_entry_t                 head_e;
  rob_wr_t                    wr [NWR];

  for (genvar p = 0; p < NWR; p++) begin : g_wr
    assign wr[p].valid = wr_valid[p];
    assign wr[p].idx   = wr_idx[p];
    assign wr[p].data  = wr_data[p];
  end

  rob_alloc_ctl #(
    .DW  (ROB_DEPTHLOG2),
    .NWR (NWR)
  ) u_ctl (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush       (flush),
    .alloc_req   (alloc_req),
    .retire      (retire),
    .wr_idx      (wr_idx),
    .alloc_ready (alloc_ready),
    .accept      (accept),
    .alloc_slot  (alloc_slot),
    .head        (head),
    .count       (count),
    .wr_alloc    (wr_alloc)
  );

  assign empty  = (count == '0);
  assign head_e = entries[head];
  assign retire = !empty && done[head];
  assign wr_ok  = wr_valid & wr_alloc;

  // Later ports override earlier ones on a same-slot collision.
  always_ff @(posedge clock) begin
    if (reset_n && !flush) begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_ok[p]) entries[wr[p].idx] <= wr[p].data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      done         <= '0;
      retire_valid <= 1'b0;
      rf_wr_en     <= 1'b0;
      rf_wr_reg    <= '0;
      rf_wr_data   <= '0;
      wr_err       <= 1'b0;
    end else if (flush) begin
      done         <= '0;
      retire_valid <= 1'b0;
      rf_wr_en     <= 1'b0;
      wr_err       <= 1'b0;
    end else begin
      retire_valid <= retire;
      rf_wr_en     <= retire & head_e.dest_reg_valid;
      if (retire) begin
        rf_wr_reg  <= head_e.dest_reg;
        rf_wr_data <= head_e.result_lo;
        done[head] <= 1'b0;
      end
      if (accept) done[alloc_slot] <= 1'b0;
      // A write landing on the retiring head still takes effect.
      for (int p = 0; p < NWR; p++) begin
        if (wr_ok[p]) done[wr[p].idx] <= 1'b1;
      end
      wr_err <= |(wr_valid & ~wr_alloc);
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: directed scenarios plus random traffic
// compared against an occupancy/array reference model.
module tb_rob_commit;
  import pipTypes::*;

  logic                  clock;
  logic                  reset_n;
  logic                  flush;
  logic                  alloc_req;
  logic                  alloc_ready;
  logic [3:0]            alloc_slot;
  logic [1:0]            wr_valid;
  logic [1:0][3:0]       wr_idx;
  rob_entry_t [1:0]      wr_data;
  logic                  wr_err;
  logic                  rf_wr_en;
  logic [4:0]            rf_wr_reg;
  logic [31:0]           rf_wr_data;
  logic                  retire_valid;
  logic [4:0]            count;
  logic                  empty;

  rob_commit #(.ROB_DEPTHLOG2(4), .NWR(2)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .flush        (flush),
    .alloc_req    (alloc_req),
    .alloc_ready  (alloc_ready),
    .alloc_slot   (alloc_slot),
    .wr_valid     (wr_valid),
    .wr_idx       (wr_idx),
    .wr_data      (wr_data),
    .wr_err       (wr_err),
    .rf_wr_en     (rf_wr_en),
    .rf_wr_reg    (rf_wr_reg),
    .rf_wr_data   (rf_wr_data),
    .retire_valid (retire_valid),
    .count        (count),
    .empty        (empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a circular window of live slots.
  bit         m_done [16];
  rob_entry_t m_ent  [16];
  int         m_head, m_tail, m_cnt;
  bit         m_rv, m_en, m_err;
  logic [4:0] m_reg;
  logic [31:0] m_data;

  function automatic rob_entry_t mk(int r, int d, bit v);
    rob_entry_t e;
    e.dest_reg       = 5'(r);
    e.result_lo      = 32'(d);
    e.dest_reg_valid = v;
    return e;
  endfunction

  function automatic bit live(int s);
    return ((s - m_head + 16) % 16) < m_cnt;
  endfunction

  task automatic m_clear();
    m_head = 0; m_tail = 0; m_cnt = 0;
    m_rv = 0; m_en = 0; m_err = 0;
    for (int i = 0; i < 16; i++) m_done[i] = 0;
  endtask

  task automatic m_step(bit al, bit fl, bit [1:0] wv, int i0, int i1,
                        rob_entry_t d0, rob_entry_t d1);
    bit acc, ret;
    bit nd [16];
    int idx [2];
    rob_entry_t dd [2];
    if (fl) begin
      m_clear();
      return;
    end
    idx[0] = i0; idx[1] = i1; dd[0] = d0; dd[1] = d1;
    acc = al && (m_cnt != 16);
    ret = (m_cnt != 0) && m_done[m_head];
    nd = m_done;
    m_err = 0;
    if (ret) begin
      m_rv = 1; m_en = m_ent[m_head].dest_reg_valid;
      m_reg = m_ent[m_head].dest_reg;
      m_data = m_ent[m_head].result_lo;
      nd[m_head] = 0;
    end else begin
      m_rv = 0; m_en = 0;
    end
    if (acc) nd[m_tail] = 0;
    for (int p = 0; p < 2; p++) begin
      if (wv[p]) begin
        if (live(idx[p])) begin
          m_ent[idx[p]] = dd[p];
          nd[idx[p]] = 1;
        end else m_err = 1;
      end
    end
    m_done = nd;
    m_head = (m_head + int'(ret)) % 16;
    m_tail = (m_tail + int'(acc)) % 16;
    m_cnt  = m_cnt + int'(acc) - int'(ret);
  endtask

  task automatic cmp_all();
    chk("alloc_ready", alloc_ready, m_cnt != 16);
    chk("alloc_slot", alloc_slot, m_tail);
    chk("count", count, m_cnt);
    chk("empty", empty, m_cnt == 0);
    chk("retire_valid", retire_valid, m_rv);
    chk("rf_wr_en", rf_wr_en, m_en);
    chk("rf_wr_reg", rf_wr_reg, m_reg);
    chk("rf_wr_data", rf_wr_data, m_data);
    chk("wr_err", wr_err, m_err);
  endtask

  task automatic tick(bit al, bit fl, bit [1:0] wv, int i0, int i1,
                      rob_entry_t d0, rob_entry_t d1);
    alloc_req  = al;
    flush      = fl;
    wr_valid   = wv;
    wr_idx[0]  = 4'(i0);
    wr_idx[1]  = 4'(i1);
    wr_data[0] = d0;
    wr_data[1] = d1;
    m_step(al, fl, wv, i0, i1, d0, d1);
    @(posedge clock);
    @(negedge clock);
    cmp_all();
  endtask

  task automatic idle();
    tick(0, 0, 2'b00, 0, 0, mk(0, 0, 0), mk(0, 0, 0));
  endtask

  task automatic alloc_n(int n);
    for (int i = 0; i < n; i++)
      tick(1, 0, 2'b00, 0, 0, mk(0, 0, 0), mk(0, 0, 0));
  endtask

  task automatic wr1(int s, int r, int d, bit v);
    tick(0, 0, 2'b01, s, 0, mk(r, d, v), mk(0, 0, 0));
  endtask

  task automatic do_flush();
    tick(0, 1, 2'b00, 0, 0, mk(0, 0, 0), mk(0, 0, 0));
  endtask

  function automatic int pick();
    if ($urandom % 5 == 0) return int'($urandom % 16);
    return (m_head + int'($urandom % (m_cnt + 1))) % 16;
  endfunction

  initial begin
    reset_n = 0; flush = 0; alloc_req = 0; wr_valid = 0;
    wr_idx = '0; wr_data = '0;
    m_clear(); m_reg = 0; m_data = 0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    cmp_all();
    chk("rst_alloc_slot", alloc_slot, 0);
    chk("rst_rf_wr_data", rf_wr_data, 0);
    reset_n = 1;

    // In-order retire of out-of-order writes.
    alloc_n(3);
    wr1(2, 5, 'h30, 1);
    wr1(0, 3, 'h10, 1);
    wr1(1, 4, 'h20, 1);
    chk("ord0_data", rf_wr_data, 'h10);
    chk("ord0_reg", rf_wr_reg, 3);
    idle();
    chk("ord1_data", rf_wr_data, 'h20);
    idle();
    chk("ord2_data", rf_wr_data, 'h30);
    idle();

    // Full buffer, retire, wrap.
    do_flush();
    alloc_n(16);
    chk("full_ready", alloc_ready, 0);
    chk("full_count", count, 16);
    wr1(0, 1, 'h55, 1);
    chk("full_still", alloc_ready, 0);
    idle();
    chk("full_ret", retire_valid, 1);
    chk("full_reready", alloc_ready, 1);
    chk("wrap_slot", alloc_slot, 0);
    alloc_n(1);
    chk("wrap_count", count, 16);

    // Dual-port same-slot write: port 1 wins.
    do_flush();
    alloc_n(4);
    tick(0, 0, 2'b11, 3, 3, mk(9, 'hAA, 1), mk(9, 'hBB, 1));
    chk("dual_err", wr_err, 0);
    tick(0, 0, 2'b11, 0, 1, mk(1, 1, 1), mk(2, 2, 1));
    wr1(2, 3, 3, 1);
    idle();
    idle();
    idle();
    chk("dual_data", rf_wr_data, 'hBB);

    // Unallocated write and no-dest retire.
    do_flush();
    alloc_n(2);
    wr1(7, 6, 'h77, 1);
    chk("unalloc_err", wr_err, 1);
    idle();
    chk("unalloc_pulse", wr_err, 0);
    chk("unalloc_noret", retire_valid, 0);
    wr1(0, 8, 'h88, 0);
    idle();
    chk("nodst_rv", retire_valid, 1);
    chk("nodst_en", rf_wr_en, 0);

    // Flush beats pending retire and alloc.
    do_flush();
    alloc_n(1);
    wr1(0, 2, 'h99, 1);
    tick(1, 1, 2'b00, 0, 0, mk(0, 0, 0), mk(0, 0, 0));
    chk("flush_rv", retire_valid, 0);
    chk("flush_count", count, 0);
    chk("flush_slot", alloc_slot, 0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      bit al, fl;
      bit [1:0] wv;
      al = ($urandom % 4) != 0;
      fl = ($urandom % 80) == 0;
      wv = 2'($urandom);
      tick(al, fl, wv, pick(), pick(),
           mk(int'($urandom % 32), int'($urandom), 1'($urandom)),
           mk(int'($urandom % 32), int'($urandom), 1'($urandom)));
      if (n == 1500) begin
        reset_n = 0;
        @(posedge clock);
        @(negedge clock);
        m_clear(); m_reg = 0; m_data = 0;
        reset_n = 1;
        cmp_all();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rob_commit.md
# rob_commit

Reorder buffer receiving out-of-order result writes from the execute wrappers and retiring them in program order to the register file. Dispatch allocates one slot per instruction. Execute units write `rob_entry_t` results into that slot. The oldest completed entry retires each cycle as a registered register-file write.

## Interface
- `ROB_DEPTHLOG2`, 4: log2 of entry count; DEPTH = 2**ROB_DEPTHLOG2.
- `NWR`, 2: number of result write ports.

- `clock`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `flush`  in  1  discard all entries (synchronous).
- `alloc_req`  in  1  dispatch requests a slot.
- `alloc_ready`  out  1  a slot is available.
- `alloc_slot`  out  ROB_DEPTHLOG2  slot granted if `alloc_req & alloc_ready` this cycle.
- `wr_valid`  in  NWR  per-port result write strobe.
- `wr_idx`  in  NWR×ROB_DEPTHLOG2  per-port target slot.
- `wr_data`  in  NWR×rob_entry_t  per-port result (`result_lo`, `dest_reg`, `dest_reg_valid`).
- `wr_err`  out  1  registered pulse: a write targeted an unallocated slot.
- `rf_wr_en`  out  1  registered: retiring entry writes a register.
- `rf_wr_reg`  out  5  registered retiring `dest_reg`.
- `rf_wr_data`  out  32  registered retiring `result_lo`.
- `retire_valid`  out  1  registered: an entry retired (also when `dest_reg_valid=0`).
- `count`  out  ROB_DEPTHLOG2+1  occupied entries.
- `empty`  out  1  `count==0`.

## Operation
- **State:**
  - `head`: oldest entry.
  - `tail`: next slot to allocate.
  - `count`: occupied entries.
  - Per entry: a `rob_entry_t` and a `done` bit.
  - Pointers wrap modulo DEPTH.
- **Allocation:**
  - `alloc_ready = (count != DEPTH)`, computed from the registered count. A retire in the same cycle does not free the slot early.
  - `alloc_slot = tail`.
  - On accept: `done[tail]<=0`, `tail<=tail+1`.
- **Allocated test:** slot s is allocated iff `((s-head) mod DEPTH) < count`. The test uses pre-edge values.
- **Result write:**
  - Valid port to an allocated slot: `entry<=wr_data`, `done<=1`.
  - Overwriting an already-done entry is permitted and is not an error.
  - Write to an unallocated slot (including the slot being allocated this same cycle): dropped, and `wr_err` pulses next cycle.
  - Two ports to the same slot: highest port index wins, no error.
- **Retire:**
  - Condition: `count!=0 & done[head]`, evaluated on pre-edge state.
  - Effect: `retire_valid<=1`, `rf_wr_en<=entry.dest_reg_valid`, `rf_wr_reg/rf_wr_data` loaded from the entry, `done[head]<=0`, `head++`.
  - Otherwise `retire_valid<=0` and `rf_wr_en<=0`; `rf_wr_reg` and `rf_wr_data` hold.
  - At most one retire per cycle.
- **Count:** `count <= count + accept - retire`. Simultaneous alloc and retire leaves count unchanged.
- **Same-slot write and retire:** retire uses the old `done` and data. The write lands afterwards. If the entry was not done, it is not retired this cycle.
- **Flush:** highest priority. Next state: `head=tail=count=0`, all `done=0`, `rf_wr_en=retire_valid=wr_err=0`. Alloc, writes and retire in that cycle are ignored.
- **Reset:** same state as flush, plus `rf_wr_reg=0` and `rf_wr_data=0`. After reset: `alloc_ready=1`, `alloc_slot=0`, `empty=1`, `count=0`.

## Timing
- Alloc accepted at edge E: the slot becomes writable for writes sampled at E+1 or later.
- Write sampled at edge E: the entry may retire at edge E+1. `rf_wr_*` is valid during cycle E+1..E+2. Minimum write-to-regfile latency is 2 edges; there is no bypass.
- Full (count=DEPTH) with a retire in the same cycle: `alloc_ready` stays 0 that cycle and reasserts the next cycle.
- Throughput: 1 alloc and 1 retire per cycle sustained.
- `rf_wr_en` is a single-cycle pulse per retired entry.
- `reset_n` or `flush` asserted mid-stream takes effect at that edge. No partial retire occurs.

## Structure
- `pipTypes` owns `rob_entry_t` (existing).
- Add to `pipTypes`: `rob_idx_t` sized by ROB_DEPTHLOG2 and a `rob_wr_t` port bundle (valid, idx, data).
- One sub-module: `rob_alloc_ctl`, holding the head/tail/count pointers, `alloc_ready` and the allocated-range test. Entry storage and the retire registers live in `rob_commit`.

## Test plan
- Reset → `alloc_ready=1`, `alloc_slot=0`, `empty=1`, `rf_wr_en=0`, `rf_wr_data=0`.
- Allocate slots 0,1,2, then write slot 2 (r5=0x30), slot 0 (r3=0x10), slot 1 (r4=0x20) on separate cycles → retires in order r3=0x10, r4=0x20, r5=0x30. Slot 0 retires 2 edges after its write; slots 1 and 2 retire on consecutive cycles.
- Fill 16 entries → `alloc_ready=0`, `count=16`. Complete slot 0 → retire; `alloc_ready` returns one cycle after the retire, and the next alloc gets slot 0 (wrap).
- Port 0 and port 1 both write slot 3 (0xAA and 0xBB) → retired data is 0xBB, `wr_err=0`.
- Write slot 7 while `count=2` (head=0) → `wr_err` pulses one cycle and nothing retires from slot 7. An entry with `dest_reg_valid=0` retires with `retire_valid=1`, `rf_wr_en=0`.
- Flush asserted in the same cycle as a pending retire and an alloc → no retire, `count=0`, `alloc_slot=0` next cycle.
